// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter and its receiver sibling:
// FSM encoding, frame constants and timing helpers.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RTS,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_ACK,
        ST_DONE
    } ps2_tx_state_e;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_SHIFT_BITS = PS2_DATA_BITS + 1;

    function automatic longint cycles_per_us(input longint clk_hz);
        return clk_hz / 64'd1_000_000;
    endfunction

    // Multiply before dividing so non-integer MHz clocks keep full precision.
    function automatic longint us_to_cycles(input longint clk_hz, input longint us);
        return (clk_hz * us) / 64'd1_000_000;
    endfunction

    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock conditioner: 2-flop synchronizer, 8-sample glitch filter and a
// one-cycle falling-edge pulse aligned with the filtered level change.
module ps2_clk_filter (
    input  logic clk,
    input  logic rst,
    input  logic i_ps2c,
    output logic o_level,
    output logic o_fall_edge
);

    logic [1:0] r_sync;
    logic [7:0] r_samples;
    logic       r_level;
    logic       r_fall;
    logic       w_level_next;

    // Hysteresis: the level only moves once all eight samples agree.
    always_comb begin
        w_level_next = r_level;
        if (r_samples == 8'hFF) begin
            w_level_next = 1'b1;
        end else if (r_samples == 8'h00) begin
            w_level_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync    <= 2'b11;
            r_samples <= 8'hFF;
            r_level   <= 1'b1;
            r_fall    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_ps2c};
            r_samples <= {r_samples[6:0], r_sync[1]};
            r_level   <= w_level_next;
            r_fall    <= r_level & ~w_level_next;
        end
    end

    assign o_level     = r_level;
    assign o_fall_edge = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host transmitter: request-to-send, bit-serial command frame clocked by
// the device, ACK capture and a watchdog that aborts a stalled transfer.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int RTS_US     = 100,
    parameter int TIMEOUT_US = 2000
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        ps2c,
    inout  wire        ps2d,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err
);

    localparam int RTS_CYCLES = int'(us_to_cycles(64'(CLK_HZ), 64'(RTS_US)));
    localparam int TO_CYCLES  = int'(us_to_cycles(64'(CLK_HZ), 64'(TIMEOUT_US)));
    localparam int RTS_W      = $clog2(RTS_CYCLES + 1);
    localparam int TO_W       = $clog2(TO_CYCLES + 1);
    localparam int BIT_W      = $clog2(PS2_DATA_BITS);

    localparam logic [RTS_W-1:0] RTS_LAST = RTS_W'(RTS_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PS2_DATA_BITS - 1);

    ps2_tx_state_e             r_state, w_state_next;
    logic [PS2_SHIFT_BITS-1:0] r_shift, w_shift_next;
    logic [BIT_W-1:0]          r_bit_cnt, w_bit_cnt_next;
    logic [RTS_W-1:0]          r_rts_cnt, w_rts_cnt_next;
    logic [TO_W-1:0]           r_to_cnt, w_to_cnt_next;
    logic                      r_c_oe, w_c_oe_next;
    logic                      r_d_oe, w_d_oe_next;
    logic                      r_done, w_done_next;
    logic                      r_ack_err, w_ack_err_next;
    logic [1:0]                r_d_sync;
    logic                      w_c_level;
    logic                      w_fall;
    logic                      w_timeout;

    ps2_clk_filter u_clk_filter (
        .clk         (clk),
        .rst         (rst),
        .i_ps2c      (ps2c),
        .o_level     (w_c_level),
        .o_fall_edge (w_fall)
    );

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_rts_cnt_next = r_rts_cnt;
        w_done_next    = 1'b0;
        w_ack_err_next = r_ack_err;
        w_timeout      = (r_state != ST_IDLE) && (r_state != ST_RTS) && (r_to_cnt == TO_LAST);

        case (r_state)
            ST_IDLE: begin
                if (wr_ps2) begin
                    w_shift_next   = {odd_parity(din), din};
                    w_ack_err_next = 1'b0;
                    w_rts_cnt_next = '0;
                    w_state_next   = ST_RTS;
                end
            end
            ST_RTS: begin
                if (r_rts_cnt == RTS_LAST) begin
                    w_state_next = ST_START;
                end else begin
                    w_rts_cnt_next = r_rts_cnt + RTS_W'(1);
                end
            end
            ST_START: begin
                if (w_fall) begin
                    w_bit_cnt_next = '0;
                    w_state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_fall) begin
                    // Shift in ones so the line is released once parity has gone out.
                    w_shift_next = {1'b1, r_shift[PS2_SHIFT_BITS-1:1]};
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_next = ST_PARITY;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (w_fall) begin
                    w_shift_next = {1'b1, r_shift[PS2_SHIFT_BITS-1:1]};
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_fall) begin
                    w_state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                if (w_fall) begin
                    w_ack_err_next = r_d_sync[1];
                    w_state_next   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_c_level && r_d_sync[1]) begin
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Progress on this cycle takes precedence over an expiring watchdog.
        if (w_timeout && !w_fall && (w_state_next == r_state)) begin
            w_state_next   = ST_IDLE;
            w_ack_err_next = 1'b1;
            w_done_next    = 1'b1;
        end

        if ((w_state_next != r_state) || w_fall || (r_state == ST_IDLE) || (r_state == ST_RTS)) begin
            w_to_cnt_next = '0;
        end else begin
            w_to_cnt_next = r_to_cnt + TO_W'(1);
        end

        // Line enables are decoded from the next state so they register with it.
        w_c_oe_next = (w_state_next == ST_RTS);
        case (w_state_next)
            ST_RTS:              w_d_oe_next = (w_rts_cnt_next == RTS_LAST);
            ST_START:            w_d_oe_next = 1'b1;
            ST_DATA, ST_PARITY:  w_d_oe_next = ~w_shift_next[0];
            default:             w_d_oe_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_rts_cnt <= '0;
            r_to_cnt  <= '0;
            r_c_oe    <= 1'b0;
            r_d_oe    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_d_sync  <= 2'b11;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_rts_cnt <= w_rts_cnt_next;
            r_to_cnt  <= w_to_cnt_next;
            r_c_oe    <= w_c_oe_next;
            r_d_oe    <= w_d_oe_next;
            r_done    <= w_done_next;
            r_ack_err <= w_ack_err_next;
            r_d_sync  <= {r_d_sync[0], ps2d};
        end
    end

    assign ps2c = r_c_oe ? 1'b0 : 1'bz;
    assign ps2d = r_d_oe ? 1'b0 : 1'bz;

    assign tx_idle      = (r_state == ST_IDLE);
    assign tx_done_tick = r_done;
    assign ack_err      = r_ack_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: device model clocks frames, a scoreboard
// matches each completion against the expected ACK outcome.
module tb_ps2_host_tx;

    localparam int CLK_HZ     = 10_000_000;
    localparam int RTS_US     = 100;
    localparam int TIMEOUT_US = 2000;
    localparam int RTS_CYC    = 1000;
    localparam int TO_CYC     = 20000;
    localparam int HALF       = 40;

    typedef struct {
        logic [7:0] din;
        bit         dev_ack;
        bit         exp_par;
        bit         exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] din;
        bit         exp_err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       ack_err;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    wire        ps2c;
    wire        ps2d;

    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[4];

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_HZ     (CLK_HZ),
        .RTS_US     (RTS_US),
        .TIMEOUT_US (TIMEOUT_US)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .ack_err      (ack_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Scoreboard: each completion pops the oldest accepted command.
    always @(negedge clk) begin
        if (tx_done_tick === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done tick expected none");
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("ack_err din=%02h", mon_e.din), 32'(ack_err), 32'(mon_e.exp_err));
            end
        end
    end

    task automatic start_write(input logic [7:0] b, input bit exp_err);
        int guard;
        guard = 0;
        while (tx_idle !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("idle_before_write", 32'(tx_idle), 32'd1);
        wr_ps2 = 1'b1;
        din    = b;
        exp_q.push_back('{din: b, exp_err: exp_err});
        @(negedge clk);
        wr_ps2 = 1'b0;
    endtask

    task automatic measure_rts(output int len);
        int guard;
        guard = 0;
        while (ps2c !== 1'b0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        len = 0;
        while (ps2c === 1'b0 && len < RTS_CYC + 100) begin
            len++;
            @(negedge clk);
        end
        check("start_bit_at_release", 32'(ps2d), 32'd0);
    endtask

    // Device samples the data line at the end of each clock-high phase.
    task automatic dev_clock(input bit do_ack, input int n_falls, output logic [10:0] frame);
        frame = '0;
        repeat (HALF) @(negedge clk);
        frame[0] = ps2d;
        for (int k = 1; k <= 12 && k <= n_falls; k++) begin
            dev_c_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_c_low = 1'b0;
            repeat (HALF) @(negedge clk);
            if (k <= 10) frame[k] = ps2d;
            if (k == 10 && do_ack) dev_d_low = 1'b1;
        end
        dev_d_low = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int bound);
        int guard;
        guard = 0;
        while (done_cnt == d0 && guard < bound) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", 32'(done_cnt > d0), 32'd1);
    endtask

    task automatic check_frame(input logic [10:0] frame, input logic [7:0] b, input bit par);
        check("frame_start", 32'(frame[0]), 32'd0);
        check("frame_data", 32'(frame[8:1]), 32'(b));
        check("frame_parity", 32'(frame[9]), 32'(par));
        check("frame_stop", 32'(frame[10]), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit dev_ack, input bit exp_par, input bit exp_err);
        logic [10:0] frame;
        int          rts_len;
        int          d0;
        d0 = done_cnt;
        start_write(b, exp_err);
        measure_rts(rts_len);
        check("rts_len", 32'(rts_len), 32'(RTS_CYC));
        dev_clock(dev_ack, 12, frame);
        check_frame(frame, b, exp_par);
        wait_done(d0, 300);
        repeat (50) @(negedge clk);
        check("done_once", 32'(done_cnt - d0), 32'd1);
        check("idle_after", 32'(tx_idle), 32'd1);
        check("ack_err_after", 32'(ack_err), 32'(exp_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] frame;
        int          rts_len;
        int          d0;
        int          cnt;

        vecs[0] = '{din: 8'hF4, dev_ack: 1'b1, exp_par: 1'b0, exp_err: 1'b0};
        vecs[1] = '{din: 8'hFF, dev_ack: 1'b1, exp_par: 1'b1, exp_err: 1'b0};
        vecs[2] = '{din: 8'h3C, dev_ack: 1'b0, exp_par: 1'b1, exp_err: 1'b1};
        vecs[3] = '{din: 8'h01, dev_ack: 1'b1, exp_par: 1'b0, exp_err: 1'b0};

        repeat (5) @(negedge clk);
        check("rst_tx_idle", 32'(tx_idle), 32'd1);
        check("rst_done", 32'(tx_done_tick), 32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        check("rst_ps2c", 32'(ps2c), 32'd1);
        check("rst_ps2d", 32'(ps2d), 32'd1);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            send_byte(vecs[i].din, vecs[i].dev_ack, vecs[i].exp_par, vecs[i].exp_err);
        end

        // Device never clocks: watchdog abort.
        d0 = done_cnt;
        start_write(8'h55, 1'b1);
        measure_rts(rts_len);
        check("to_rts_len", 32'(rts_len), 32'(RTS_CYC));
        cnt = 0;
        while (tx_done_tick !== 1'b1 && cnt < TO_CYC + 200) begin
            @(negedge clk);
            cnt++;
        end
        check("to_latency_in_window", 32'((cnt >= TO_CYC - 1) && (cnt <= TO_CYC + 2)), 32'd1);
        @(negedge clk);
        check("to_ps2c_released", 32'(ps2c), 32'd1);
        check("to_ps2d_released", 32'(ps2d), 32'd1);
        check("to_idle", 32'(tx_idle), 32'd1);
        check("to_ack_err", 32'(ack_err), 32'd1);
        repeat (50) @(negedge clk);
        check("to_done_once", 32'(done_cnt - d0), 32'd1);

        // Second write during DATA must be ignored.
        d0 = done_cnt;
        start_write(8'hF4, 1'b0);
        measure_rts(rts_len);
        fork
            dev_clock(1'b1, 12, frame);
            begin
                repeat (HALF * 7) @(negedge clk);
                check("busy_at_second_wr", 32'(tx_idle), 32'd0);
                wr_ps2 = 1'b1;
                din    = 8'h00;
                @(negedge clk);
                wr_ps2 = 1'b0;
            end
        join
        check_frame(frame, 8'hF4, 1'b0);
        wait_done(d0, 300);
        repeat (50) @(negedge clk);
        check("ignored_wr_done_once", 32'(done_cnt - d0), 32'd1);

        // Reset while DATA bit 4 (a zero) is on the line.
        d0 = done_cnt;
        start_write(8'hA5, 1'b0);
        measure_rts(rts_len);
        dev_clock(1'b0, 5, frame);
        check("pre_rst_ps2d_low", 32'(ps2d), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_mid_ps2d_z", 32'(ps2d), 32'd1);
        check("rst_mid_ps2c_z", 32'(ps2c), 32'd1);
        exp_q.delete();
        repeat (20) @(negedge clk);
        check("rst_mid_idle", 32'(tx_idle), 32'd1);
        check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        send_byte(8'hF4, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter RTS_US, default 100, host clock-inhibit (request-to-send) hold time in microseconds.
REQ-003 Parameter TIMEOUT_US, default 2000, maximum wait for any device clock edge before abort.
REQ-004 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 ps2c  inout  1  PS/2 clock line; the block SHALL drive only 0 or Z, never 1.
REQ-007 ps2d  inout  1  PS/2 data line; the block SHALL drive only 0 or Z, never 1.
REQ-008 wr_ps2  input  1  one-cycle write strobe; it is sampled only while tx_idle=1.
REQ-009 din  input  8  command byte, captured on an accepted wr_ps2.
REQ-010 tx_idle  output  1  high when no transfer is in progress; the receiver may listen only while high.
REQ-011 tx_done_tick  output  1  one-cycle pulse at the end of a transfer, whether it succeeded or failed.
REQ-012 ack_err  output  1  valid from tx_done_tick until the next accepted wr_ps2; 1 means NACK or timeout.

Function
REQ-013 ps2c SHALL be synchronized through 2 flops, then filtered by an 8-sample shift register; the filtered level changes only when all 8 samples agree.
REQ-014 A falling edge (fall_edge) SHALL be a one-cycle pulse generated when the filtered level goes from 1 to 0.
REQ-015 The FSM states SHALL be IDLE, RTS, START, DATA, PARITY, STOP, ACK, DONE.
REQ-016 IDLE: both lines are released and tx_idle=1; wr_ps2 loads {odd_parity, din} into the shift register, clears ack_err, and moves to RTS.
REQ-017 Odd parity SHALL equal the inverse of the XOR of din[7:0].
REQ-018 RTS: ps2c is driven low for exactly RTS_US*CLK_HZ/1e6 cycles (10000 at defaults); ps2d is driven low during the final cycle, then the FSM moves to START.
REQ-019 START: ps2c is released and ps2d held low; on fall_edge, ps2d takes bit 0 and the FSM moves to DATA with bit counter=0.
REQ-020 DATA: on each fall_edge the next bit (LSB first) SHALL be put on ps2d; after the 8th data bit has been presented and clocked, the FSM moves to PARITY.
REQ-021 PARITY: on fall_edge, ps2d is released (stop bit = 1) and the FSM moves to STOP.
REQ-022 STOP: on fall_edge, the FSM moves to ACK.
REQ-023 ACK: the synchronized ps2d is sampled at the ACK-state fall_edge; ack_err = sampled value (0 = ACK). The FSM then moves to DONE.
REQ-024 DONE: the FSM waits for the filtered ps2c to be high and the synchronized ps2d to be high (bus idle), pulses tx_done_tick, and returns to IDLE.
REQ-025 A timeout counter SHALL reload on each state change and each fall_edge.
REQ-026 If the timeout counter reaches TIMEOUT_US worth of cycles in any state other than IDLE or RTS, both lines are released, ack_err=1, tx_done_tick is pulsed, and the FSM goes to IDLE.
REQ-027 wr_ps2 asserted while tx_idle=0 SHALL be ignored, with no queuing.
REQ-028 Counter widths SHALL be derived with $clog2 from the parameters; no counter may wrap before its terminal count.
REQ-029 Every output change happens on a clk edge; the output-enable flops SHALL be registered, with no combinational path from any input to ps2c/ps2d.

Reset
REQ-030 While rst=0: FSM=IDLE, ps2c/ps2d released (Z), tx_idle=1, tx_done_tick=0, ack_err=0, all counters and filters cleared, filter preset to 1s.
REQ-031 Reset asserted mid-transfer SHALL release both lines within the same cycle (asynchronously) and SHALL NOT produce tx_done_tick.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the PS/2 frame constants (11 bits, odd parity), and the cycles-per-microsecond helper.
REQ-033 One sub-module, ps2_clk_filter (sync + 8-sample filter + fall_edge), is natural; the mouse receiver SHALL reuse it.

Verification
REQ-034 Send din=8'hF4 with the device model ACKing: ps2c is held low for 10000 cycles; the device sees bits 0,0,1,0,1,1,1,1, parity 0, stop 1; tx_done_tick fires once; ack_err=0.
REQ-035 Send din=8'hFF: parity bit = 1; ack_err=0.
REQ-036 The device model leaves ps2d high at the ACK bit: ack_err=1 when tx_done_tick fires.
REQ-037 The device model never clocks after RTS: at 2000 us, lines are released, ack_err=1, one tx_done_tick is issued, and tx_idle=1.
REQ-038 A second wr_ps2 with din=8'h00 is pulsed during DATA: the frame still carries the first byte and exactly one tx_done_tick is issued.
REQ-039 rst=0 is asserted during DATA bit 4: ps2c and ps2d go to Z immediately, no tx_done_tick is issued, and a new 8'hF4 send after release completes with ACK.
